wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 8, the number of result lanes per write beat.
REQ-002 SHALL have parameter OUTPUT_DATA_WIDTH, default 16, the width of one quantized lane.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per requester FIFO (power of two, >=2).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on posedge.
REQ-005 SHALL have port srstn, input, 1 bit, synchronous active-high reset (1 = reset).
REQ-006 SHALL have ports we_a, we_b, we_c, input, 1 bit each, the requester write strobes.
REQ-007 SHALL have ports waddr_a, waddr_b, waddr_c, input, 6 bits each, the requester row addresses.
REQ-008 SHALL have ports wdata_a, wdata_b, wdata_c, input, ARRAY_SIZE*OUTPUT_DATA_WIDTH bits each, the requester row data.
REQ-009 SHALL have port out_ready, input, 1 bit; when 1, the shared SRAM port accepts a write this cycle.
REQ-010 SHALL have port out_we, output, 1 bit, the shared SRAM write enable.
REQ-011 SHALL have port out_addr, output, 8 bits, {src[1:0], waddr[5:0]} with src a=0, b=1, c=2.
REQ-012 SHALL have port out_data, output, ARRAY_SIZE*OUTPUT_DATA_WIDTH bits, the shared SRAM write data.
REQ-013 SHALL have port overflow, output, 3 bits, sticky drop flags [0]=a, [1]=b, [2]=c.
REQ-014 SHALL have port wr_count, output, 8 bits, the number of beats issued on out_we, wrapping modulo 256.
REQ-015 SHALL have port idle, output, 1 bit; 1 when all FIFOs are empty and out_we=0.

Function
REQ-016 SHALL give each requester an independent FIFO_DEPTH-entry FIFO holding {waddr, wdata}.
REQ-017 SHALL push an entry when we_x=1 and (the FIFO is not full, or the FIFO is popped in the same cycle); a push-and-pop on a full FIFO leaves the count unchanged.
REQ-018 SHALL drop the beat when we_x=1 and the FIFO is full and not popped, and SHALL set overflow[x] at the next edge.
REQ-019 SHALL arbitrate only in cycles with out_ready=1, granting the first non-empty FIFO in round-robin order starting after last_grant.
REQ-020 SHALL pop the granted FIFO at the same edge, update last_grant to the granted source, and register the popped entry onto out_we/out_addr/out_data for the following cycle.
REQ-021 SHALL drive out_we=0 in the cycle after any edge with no grant (out_ready=0 or all FIFOs empty); out_addr and out_data SHALL hold their previous values.
REQ-022 SHALL leave last_grant unchanged when there is no grant.
REQ-023 SHALL have a minimum latency of 2 cycles: a beat pushed at edge N into an empty FIFO, with out_ready=1 and no competitors, appears on out_* during the cycle after edge N+1.
REQ-024 SHALL guarantee fairness: with all three FIFOs non-empty and out_ready held at 1, grants rotate a, b, c, a, ... with no source granted twice before every non-empty source is granted once.
REQ-025 SHALL make simultaneous strobes on all three requesters in one cycle all accepted if not full; ordering across sources follows REQ-019, and order within a source is FIFO.
REQ-026 SHALL increment wr_count at every edge where out_we is registered to 1, wrapping 255->0.
REQ-027 SHALL clear an overflow bit only on reset.
REQ-028 SHALL compute idle combinationally from the FIFO counts and out_we.

Reset
REQ-029 SHALL, with srstn=1 at a posedge, empty all FIFOs and set out_we=0, out_addr=0, out_data=0, overflow=0, wr_count=0, and last_grant=c (so a has first priority).
REQ-030 SHALL discard pending entries when reset is asserted mid-operation, ignore strobes during reset cycles, and issue no write in the cycle after reset.

Verification
REQ-031 Single beat: we_a=1, waddr_a=5, data D, out_ready=1 -> out_we=1, out_addr=0x05, out_data=D exactly 2 cycles later; wr_count=1; idle returns to 1.
REQ-032 Contention: one-cycle strobe on a, b, c together (addr 1, 2, 3), out_ready=1 -> out_addr 0x01, 0x42, 0x83 on consecutive cycles.
REQ-033 Backpressure: out_ready=0 while 4 beats are written to b, then out_ready=1 -> 4 consecutive beats in order, no overflow.
REQ-034 Overflow: out_ready=0 and 5 beats to c with FIFO_DEPTH=4 -> overflow=3'b100; only the first 4 beats are drained after out_ready=1.
REQ-035 Full push-pop: c full, out_ready=1, we_c=1 in the grant cycle -> beat accepted, overflow stays 0, count stays 4.
REQ-036 Reset mid-drain: 3 entries queued in a, srstn pulsed for 1 cycle -> out_we=0 afterwards, idle=1, wr_count=0, and a new beat follows REQ-031 timing.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: three requester FIFOs arbitrated round-robin onto one shared SRAM write port
module wb_arbiter #(
   parameter int ARRAY_SIZE        = 8,
   parameter int OUTPUT_DATA_WIDTH = 16,
   parameter int FIFO_DEPTH        = 4
) (
   input  logic                                    clk,
   input  logic                                    srstn,
   input  logic                                    we_a,
   input  logic                                    we_b,
   input  logic                                    we_c,
   input  logic [5:0]                              waddr_a,
   input  logic [5:0]                              waddr_b,
   input  logic [5:0]                              waddr_c,
   input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] wdata_a,
   input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] wdata_b,
   input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] wdata_c,
   input  logic                                    out_ready,
   output logic                                    out_we,
   output logic [7:0]                              out_addr,
   output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] out_data,
   output logic [2:0]                              overflow,
   output logic [7:0]                              wr_count,
   output logic                                    idle
);
   localparam int DW = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
   localparam int EW = DW + 6;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam bit [AW:0] FULL = FIFO_DEPTH[AW:0];

   logic [2:0]    we, push, pop, ne;
   logic [EW-1:0] went [3];
   logic [EW-1:0] mem_q [3][FIFO_DEPTH];
   logic [EW-1:0] mem_d [3][FIFO_DEPTH];
   logic [AW-1:0] rd_q [3], rd_d [3], wr_q [3], wr_d [3];
   logic [AW:0]   cnt_q [3], cnt_d [3];
   logic [1:0]    last_q, last_d, s1, s2, gnt;
   logic          gnt_v;
   logic [2:0]    ovf_q, ovf_d;
   logic          out_we_q, out_we_d;
   logic [7:0]    out_addr_q, out_addr_d, wr_count_q, wr_count_d;
   logic [DW-1:0] out_data_q, out_data_d;

   assign we   = {we_c, we_b, we_a};
   assign went = '{{waddr_a, wdata_a}, {waddr_b, wdata_b}, {waddr_c, wdata_c}};

   // Round-robin order is the two sources after last_q, then last_q itself.
   always_comb begin
      ne    = {cnt_q[2] != '0, cnt_q[1] != '0, cnt_q[0] != '0};
      s1    = last_q == 2'd2 ? 2'd0 : last_q + 2'd1;
      s2    = s1 == 2'd2 ? 2'd0 : s1 + 2'd1;
      gnt   = ne[s1] ? s1 : ne[s2] ? s2 : last_q;
      gnt_v = out_ready && |ne;
   end

   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < 3; i++) begin
         pop[i]   = gnt_v && gnt == 2'(i);
         push[i]  = we[i] && (cnt_q[i] != FULL || pop[i]);
         cnt_d[i] = cnt_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
         wr_d[i]  = wr_q[i] + AW'(push[i]);
         rd_d[i]  = rd_q[i] + AW'(pop[i]);
         ovf_d[i] = ovf_q[i] | (we[i] & ~push[i]);
         if (push[i]) mem_d[i][wr_q[i]] = went[i];
      end
      last_d     = gnt_v ? gnt : last_q;
      out_we_d   = gnt_v;
      out_addr_d = gnt_v ? {gnt, mem_q[gnt][rd_q[gnt]][EW-1:DW]} : out_addr_q;
      out_data_d = gnt_v ? mem_q[gnt][rd_q[gnt]][DW-1:0] : out_data_q;
      wr_count_d = wr_count_q + 8'(gnt_v);
   end

   always_ff @(posedge clk) mem_q <= mem_d;

   always_ff @(posedge clk) begin
      if (srstn) begin
         cnt_q      <= '{default: '0};
         rd_q       <= '{default: '0};
         wr_q       <= '{default: '0};
         last_q     <= 2'd2;
         ovf_q      <= '0;
         out_we_q   <= 1'b0;
         out_addr_q <= '0;
         out_data_q <= '0;
         wr_count_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         last_q     <= last_d;
         ovf_q      <= ovf_d;
         out_we_q   <= out_we_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign out_we   = out_we_q;
   assign out_addr = out_addr_q;
   assign out_data = out_data_q;
   assign overflow = ovf_q;
   assign wr_count = wr_count_q;
   assign idle     = cnt_q[0] == '0 && cnt_q[1] == '0 && cnt_q[2] == '0 && !out_we_q;
endmodule
